// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single write port (WE3/A3/WD3) between two
//   writeback requesters with round-robin arbitration and valid/ready
//   handshakes. Also keeps a busy scoreboard of in-flight destinations and a
//   saturating count of cycles in which both requesters were valid.
//
//   Optional feature macro: RF_WB_BYPASS_EN
//     defined   -> RD1/RD2 forward WD3 when the registered write targets the
//                  read address (address 0 never forwarded)
//     undefined -> RD1/RD2 pass RD1_IN/RD2_IN straight through
//
// Ports
//   CLK, RST_N                  clock (rising edge), async active-low reset
//   RQn_VALID/READY/ADDR/DATA   requester n write handshake (n = 0, 1)
//   ALLOC_VALID, ALLOC_ADDR     mark a destination register busy
//   WE3, A3, WD3                registered register-file write port
//   BUSY                        scoreboard, bit n set while reg n is pending
//   CONFLICT_CNT                saturating count of both-valid cycles
//   A1, A2, RD1_IN, RD2_IN      register-file read addresses and raw data
//   RD1, RD2                    read data after optional bypass
module rf_wb_arbiter #(
   parameter int A_WIDTH   = 5,
   parameter int D_WIDTH   = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    RQ0_VALID,
   output logic                    RQ0_READY,
   input  logic [A_WIDTH-1:0]      RQ0_ADDR,
   input  logic [D_WIDTH-1:0]      RQ0_DATA,
   input  logic                    RQ1_VALID,
   output logic                    RQ1_READY,
   input  logic [A_WIDTH-1:0]      RQ1_ADDR,
   input  logic [D_WIDTH-1:0]      RQ1_DATA,
   input  logic                    ALLOC_VALID,
   input  logic [A_WIDTH-1:0]      ALLOC_ADDR,
   output logic                    WE3,
   output logic [A_WIDTH-1:0]      A3,
   output logic [D_WIDTH-1:0]      WD3,
   output logic [2**A_WIDTH-1:0]   BUSY,
   output logic [CNT_WIDTH-1:0]    CONFLICT_CNT,
   input  logic [A_WIDTH-1:0]      A1,
   input  logic [A_WIDTH-1:0]      A2,
   input  logic [D_WIDTH-1:0]      RD1_IN,
   input  logic [D_WIDTH-1:0]      RD2_IN,
   output logic [D_WIDTH-1:0]      RD1,
   output logic [D_WIDTH-1:0]      RD2
);

   localparam int NREG = 2**A_WIDTH;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // 1 = requester 1 was granted most recently; reset value lets requester 0
   // win the first conflict.
   logic                 last_gnt;
   logic                 gnt0;
   logic                 gnt1;
   logic                 accept;
   logic [A_WIDTH-1:0]   win_addr;
   logic [D_WIDTH-1:0]   win_data;
   logic [NREG-1:0]      busy_nxt;

   // Grant depends only on VALIDs and the pointer, never on READY.
   assign gnt0      = RQ0_VALID && (!RQ1_VALID || last_gnt);
   assign gnt1      = RQ1_VALID && (!RQ0_VALID || !last_gnt);
   assign RQ0_READY = gnt0;
   assign RQ1_READY = gnt1;
   assign accept    = gnt0 || gnt1;
   assign win_addr  = gnt1 ? RQ1_ADDR : RQ0_ADDR;
   assign win_data  = gnt1 ? RQ1_DATA : RQ0_DATA;

   // Clear first, then set, so a same-edge reservation wins over the clear.
   always_comb begin
      busy_nxt = BUSY;
      if (accept)
         busy_nxt[win_addr] = 1'b0;
      if (ALLOC_VALID && (ALLOC_ADDR != '0))
         busy_nxt[ALLOC_ADDR] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // ---- write-port register stage ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_gnt     <= 1'b1;
         WE3          <= 1'b0;
         A3           <= '0;
         WD3          <= '0;
         BUSY         <= '0;
         CONFLICT_CNT <= '0;
      end else begin
         WE3  <= accept && (win_addr != '0);
         BUSY <= busy_nxt;
         if (accept) begin
            A3       <= win_addr;
            WD3      <= win_data;
            last_gnt <= gnt1;
         end
         if (RQ0_VALID && RQ1_VALID)
            CONFLICT_CNT <= sat_inc(CONFLICT_CNT);
      end
   end

`ifdef RF_WB_BYPASS_EN
   // Covers the cycle where BUSY has cleared but the register file has not
   // yet committed the write.
   assign RD1 = (WE3 && (A3 == A1) && (A1 != '0)) ? WD3 : RD1_IN;
   assign RD2 = (WE3 && (A3 == A2) && (A2 != '0)) ? WD3 : RD2_IN;
`else
   assign RD1 = RD1_IN;
   assign RD2 = RD2_IN;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          RQ0_VALID, RQ0_READY, RQ1_VALID, RQ1_READY;
   logic [AW-1:0] RQ0_ADDR, RQ1_ADDR, ALLOC_ADDR, A3, A1, A2;
   logic [DW-1:0] RQ0_DATA, RQ1_DATA, WD3, RD1_IN, RD2_IN, RD1, RD2;
   logic          ALLOC_VALID, WE3;
   logic [31:0]   BUSY;
   logic [CW-1:0] CONFLICT_CNT;

   int total = 0;
   int bad   = 0;

   rf_wb_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .RQ0_VALID(RQ0_VALID), .RQ0_READY(RQ0_READY), .RQ0_ADDR(RQ0_ADDR), .RQ0_DATA(RQ0_DATA),
      .RQ1_VALID(RQ1_VALID), .RQ1_READY(RQ1_READY), .RQ1_ADDR(RQ1_ADDR), .RQ1_DATA(RQ1_DATA),
      .ALLOC_VALID(ALLOC_VALID), .ALLOC_ADDR(ALLOC_ADDR),
      .WE3(WE3), .A3(A3), .WD3(WD3), .BUSY(BUSY), .CONFLICT_CNT(CONFLICT_CNT),
      .A1(A1), .A2(A2), .RD1_IN(RD1_IN), .RD2_IN(RD2_IN), .RD1(RD1), .RD2(RD2)
   );

   always #5 CLK = ~CLK;

   // Behavioural model state
   int            m_last;      // requester granted most recently
   bit            m_busy[32];
   int            m_cnt;
   bit            m_we;
   int            m_a3;
   logic [DW-1:0] m_wd;
   // Grants observed in the last step (for literal checks)
   bit            seen_g0, seen_g1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 1;
      m_cnt  = 0;
      m_we   = 0;
      m_a3   = 0;
      m_wd   = '0;
      foreach (m_busy[i]) m_busy[i] = 0;
   endtask

   function automatic logic [31:0] model_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic logic [DW-1:0] model_rd(input int a, input logic [DW-1:0] raw);
`ifdef RF_WB_BYPASS_EN
      if (m_we && m_a3 == a && a != 0) return m_wd;
`endif
      return raw;
   endfunction

   // Called at a negedge with inputs already driven: checks every output
   // against the model, then advances the model across the next posedge.
   task automatic step();
      int w;
      int wa;
      logic [DW-1:0] wd;
      bit v0, v1, al;
      int aa;
      #1;
      v0 = RQ0_VALID; v1 = RQ1_VALID; al = ALLOC_VALID; aa = ALLOC_ADDR;
      if (v0 && v1) w = (m_last == 1) ? 0 : 1;
      else if (v0)  w = 0;
      else if (v1)  w = 1;
      else          w = -1;
      wa = (w == 1) ? int'(RQ1_ADDR) : int'(RQ0_ADDR);
      wd = (w == 1) ? RQ1_DATA : RQ0_DATA;
      chk("rq0_ready", RQ0_READY, w == 0);
      chk("rq1_ready", RQ1_READY, w == 1);
      chk("we3", WE3, m_we);
      chk("a3", A3, m_a3);
      chk("wd3", WD3, m_wd);
      chk("busy", BUSY, model_busy_vec());
      chk("conflict_cnt", CONFLICT_CNT, m_cnt);
      chk("rd1", RD1, model_rd(A1, RD1_IN));
      chk("rd2", RD2, model_rd(A2, RD2_IN));
      seen_g0 = RQ0_READY;
      seen_g1 = RQ1_READY;
      @(posedge CLK);
      m_we = (w >= 0) && (wa != 0);
      if (w >= 0) begin
         m_a3 = wa;
         m_wd = wd;
         m_last = w;
         m_busy[wa] = 0;
      end
      if (al && aa != 0) m_busy[aa] = 1;
      if (v0 && v1 && m_cnt < CMAX) m_cnt++;
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      RQ0_VALID = 0; RQ1_VALID = 0; ALLOC_VALID = 0;
      RQ0_ADDR = '0; RQ1_ADDR = '0; ALLOC_ADDR = '0;
      RQ0_DATA = '0; RQ1_DATA = '0;
      A1 = '0; A2 = '0; RD1_IN = '0; RD2_IN = '0;
   endtask

   task automatic do_reset();
      RST_N = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge CLK);
      RST_N = 1;
   endtask

   bit g0_hist[4];
   bit g1_hist[4];
   bit keep0, keep1;

   initial begin
      do_reset();
      // reset state
      chk("rst_we3", WE3, 0);
      chk("rst_a3", A3, 0);
      chk("rst_wd3", WD3, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_cnt", CONFLICT_CNT, 0);

      // Sustained contention: RQ0, RQ1, RQ0, RQ1
      RQ0_VALID = 1; RQ0_ADDR = 1; RQ0_DATA = 32'h11;
      RQ1_VALID = 1; RQ1_ADDR = 2; RQ1_DATA = 32'h22;
      for (int i = 0; i < 4; i++) begin
         step();
         g0_hist[i] = seen_g0;
         g1_hist[i] = seen_g1;
      end
      chk("rr_g0", {g0_hist[0], g0_hist[1], g0_hist[2], g0_hist[3]}, 4'b1010);
      chk("rr_g1", {g1_hist[0], g1_hist[1], g1_hist[2], g1_hist[3]}, 4'b0101);
      chk("rr_cnt4", CONFLICT_CNT, 4);
      idle_inputs();

      // Single RQ0 write
      RQ0_VALID = 1; RQ0_ADDR = 5; RQ0_DATA = 32'hDEADBEEF;
      step();
      chk("w0_ready", seen_g0, 1);
      chk("w0_we3", WE3, 1);
      chk("w0_a3", A3, 5);
      chk("w0_wd3", WD3, 32'hDEADBEEF);
      RQ0_VALID = 0;
      step();
      chk("w0_we3_off", WE3, 0);

      // Write to register 0 is accepted but not performed
      RQ1_VALID = 1; RQ1_ADDR = 0; RQ1_DATA = 32'h1234;
      step();
      chk("r0_ready", seen_g1, 1);
      chk("r0_we3", WE3, 0);
      chk("r0_busy", BUSY, 0);
      RQ1_VALID = 0;

      // Scoreboard set then cleared on accept
      ALLOC_VALID = 1; ALLOC_ADDR = 7;
      step();
      ALLOC_VALID = 0;
      step();
      chk("sb_set", BUSY[7], 1);
      RQ1_VALID = 1; RQ1_ADDR = 7; RQ1_DATA = 32'h77;
      step();
      chk("sb_clr", BUSY[7], 0);
      RQ1_VALID = 0;
      // Alloc on the accept edge wins
      ALLOC_VALID = 1; ALLOC_ADDR = 7;
      step();
      RQ1_VALID = 1; RQ1_ADDR = 7; RQ1_DATA = 32'h78;
      step();
      chk("sb_alloc_wins", BUSY[7], 1);
      idle_inputs();

      // Bypass
      RQ0_VALID = 1; RQ0_ADDR = 9; RQ0_DATA = 32'hCAFE;
      step();
      RQ0_VALID = 0;
      A1 = 9; RD1_IN = 32'h0;
      #1;
`ifdef RF_WB_BYPASS_EN
      chk("byp_hit", RD1, 32'hCAFE);
`else
      chk("byp_hit", RD1, 32'h0);
`endif
      A1 = 0; RD1_IN = 32'h55;
      #1;
      chk("byp_a0", RD1, 32'h55);
      @(negedge CLK);
      m_we = 0;   // the idle cycle just clocked drops WE3
      step();

      // Asynchronous reset mid-operation
      RQ0_VALID = 1; RQ0_ADDR = 3; RQ0_DATA = 32'h3333;
      step();
      chk("ar_pre_we3", WE3, 1);
      #1;
      RST_N = 0;
      #1;
      chk("ar_we3", WE3, 0);
      chk("ar_a3", A3, 0);
      chk("ar_wd3", WD3, 0);
      chk("ar_busy", BUSY, 0);
      chk("ar_cnt", CONFLICT_CNT, 0);
      @(negedge CLK);
      do_reset();

      // Randomized traffic against the model
      keep0 = 0; keep1 = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!keep0) begin
            RQ0_VALID = ($urandom_range(0, 99) < 65);
            RQ0_ADDR  = AW'($urandom);
            RQ0_DATA  = $urandom;
         end
         if (!keep1) begin
            RQ1_VALID = ($urandom_range(0, 99) < 65);
            RQ1_ADDR  = AW'($urandom);
            RQ1_DATA  = $urandom;
         end
         ALLOC_VALID = ($urandom_range(0, 99) < 40);
         ALLOC_ADDR  = AW'($urandom);
         A1 = ($urandom_range(0, 3) == 0) ? A3 : AW'($urandom);
         A2 = ($urandom_range(0, 3) == 0) ? A3 : AW'($urandom);
         RD1_IN = $urandom;
         RD2_IN = $urandom;
         step();
         keep0 = RQ0_VALID && !seen_g0;
         keep1 = RQ1_VALID && !seen_g1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
